// File: rtl/fft_frame_sequencer.sv
// Hunts the input stream for a header run, buffers one payload frame and streams it to the FFT.
// Optional FFT_TIMEOUT_EN macro adds a WAIT_DONE watchdog that drives the sticky timeout output.
module fft_frame_sequencer #(
  parameter int unsigned     DW          = 16,
  parameter logic [DW-1:0]   HDR_WORD    = 16'hFFFF,
  parameter int unsigned     HDR_LEN     = 3,
  parameter int unsigned     FRAME_LEN   = 10,
  parameter int unsigned     TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_vld,
  input  logic          fft_ready,
  input  logic          fft_done,
  output logic          fft_start,
  output logic [DW-1:0] out_data,
  output logic          out_vld,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    drop_cnt,
  output logic          timeout
);

  localparam int unsigned IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned RW = $clog2(HDR_LEN + 1);

  typedef enum logic [2:0] {HUNT, CAPTURE, WAIT_RDY, STREAM, WAIT_DONE} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   wr_idx, wr_idx_d, rd_idx, rd_idx_d;
  logic [RW-1:0]   run, run_d;
  logic [7:0]      drop_d;
  logic            start_d, vld_d, last_d, fdone_d, busy_d;
  logic [DW-1:0]   data_d;
  logic            hdr_hit, hdr_done;
  logic [DW-1:0]   frame_buf [FRAME_LEN];

`ifdef FFT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt, tcnt_d;
  logic          tmo_d;
`endif

  assign hdr_hit  = in_vld && (in_data == HDR_WORD);
  assign hdr_done = hdr_hit && (run == RW'(HDR_LEN - 1));

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (state == CAPTURE && in_vld) frame_buf[wr_idx] <= in_data;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    wr_idx_d = wr_idx;
    rd_idx_d = rd_idx;
    run_d    = run;
    drop_d   = drop_cnt;
    start_d  = 1'b0;
    vld_d    = 1'b0;
    last_d   = 1'b0;
    data_d   = '0;
    fdone_d  = 1'b0;
`ifdef FFT_TIMEOUT_EN
    tcnt_d   = tcnt;
    tmo_d    = timeout;
`endif

    // Header detection is off while capturing so header-valued samples are kept as data.
    if (state == CAPTURE)  run_d = '0;
    else if (in_vld)       run_d = (hdr_hit && !hdr_done) ? run + RW'(1) : '0;

    if (hdr_done && (state == WAIT_RDY || state == STREAM || state == WAIT_DONE) &&
        drop_cnt != 8'hFF)
      drop_d = drop_cnt + 8'd1;

    case (state)
      HUNT: begin
        if (hdr_done) begin
          state_d  = CAPTURE;
          wr_idx_d = '0;
        end
      end
      CAPTURE: begin
        if (in_vld) begin
          wr_idx_d = wr_idx + IW'(1);
          if (wr_idx == IW'(FRAME_LEN - 1)) begin
            wr_idx_d = '0;
            state_d  = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (fft_ready) begin
          start_d  = 1'b1;
          rd_idx_d = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        vld_d    = 1'b1;
        data_d   = frame_buf[rd_idx];
        last_d   = (rd_idx == IW'(FRAME_LEN - 1));
        rd_idx_d = rd_idx + IW'(1);
        if (last_d) begin
          rd_idx_d = '0;
          state_d  = WAIT_DONE;
`ifdef FFT_TIMEOUT_EN
          tcnt_d   = '0;
`endif
        end
      end
      WAIT_DONE: begin
        if (fft_done) begin
          fdone_d = 1'b1;
          state_d = HUNT;
        end
`ifdef FFT_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          tmo_d   = 1'b1;
          state_d = HUNT;
        end else begin
          tcnt_d  = tcnt + TW'(1);
        end
`endif
      end
      default: state_d = HUNT;
    endcase

    busy_d = (state_d != HUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      wr_idx     <= '0;
      rd_idx     <= '0;
      run        <= '0;
      drop_cnt   <= '0;
      fft_start  <= 1'b0;
      out_data   <= '0;
      out_vld    <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      wr_idx     <= wr_idx_d;
      rd_idx     <= rd_idx_d;
      run        <= run_d;
      drop_cnt   <= drop_d;
      fft_start  <= start_d;
      out_data   <= data_d;
      out_vld    <= vld_d;
      out_last   <= last_d;
      busy       <= busy_d;
      frame_done <= fdone_d;
    end
  end

`ifdef FFT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt    <= tcnt_d;
      timeout <= tmo_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer (DW=16, HDR_LEN=3, FRAME_LEN=10, TIMEOUT_CYC=16).
module tb_fft_frame_sequencer;

  localparam int unsigned FL = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_vld, fft_ready, fft_done;
  logic        fft_start, out_vld, out_last, busy, frame_done, timeout;
  logic [15:0] out_data;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;
  logic [15:0] pay [FL];

  fft_frame_sequencer #(
    .DW(16), .HDR_WORD(16'hFFFF), .HDR_LEN(3), .FRAME_LEN(FL), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld),
    .fft_ready(fft_ready), .fft_done(fft_done), .fft_start(fft_start),
    .out_data(out_data), .out_vld(out_vld), .out_last(out_last), .busy(busy),
    .frame_done(frame_done), .drop_cnt(drop_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    in_vld  = 1'b1;
    in_data = w;
    tick();
    in_vld  = 1'b0;
  endtask

  task automatic send_hdr();
    repeat (3) send(16'hFFFF);
  endtask

  task automatic send_pay();
    for (int i = 0; i < FL; i++) send(pay[i]);
  endtask

  // Wait (bounded) for fft_start, then check n streamed samples.
  task automatic stream_chk(input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (fft_start) seen = 1'b1;
      else tick();
    end
    check("start_seen", 32'(seen), 32'd1);
    for (int i = 0; i < n; i++) begin
      tick();
      check("stream_vld",  32'(out_vld), 32'd1);
      check("stream_data", 32'(out_data), 32'(pay[i]));
      check("stream_last", 32'(out_last), 32'(i == FL - 1));
      if (i == 0) check("start_pulse", 32'(fft_start), 32'd0);
    end
    if (n == FL) begin
      tick();
      check("post_vld",  32'(out_vld), 32'd0);
      check("post_busy", 32'(busy), 32'd1);
    end
  endtask

  task automatic finish_frame();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("frame_done", 32'(frame_done), 32'd1);
    check("idle_busy",  32'(busy), 32'd0);
    tick();
    check("frame_done_pulse", 32'(frame_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; fft_ready = 1'b1; fft_done = 1'b0;
    #12;
    check("rst_start",   32'(fft_start), 32'd0);
    check("rst_vld",     32'(out_vld), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_drop",    32'(drop_cnt), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // fft_done outside WAIT_DONE is ignored
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    check("done_ignored", 32'(frame_done), 32'd0);

    // 1: basic frame 1..10
    for (int i = 0; i < FL; i++) pay[i] = 16'(i + 1);
    send_hdr();
    check("t1_busy", 32'(busy), 32'd1);
    send_pay();
    stream_chk(FL);
    finish_frame();

    // 2: broken header run, then header with valid gaps
    send(16'hFFFF); send(16'hFFFF); send(16'h0005); send(16'hFFFF); send(16'hFFFF);
    check("t2_no_capture", 32'(busy), 32'd0);
    send(16'hFFFF);
    check("t2_capture", 32'(busy), 32'd1);
    for (int i = 0; i < FL; i++) pay[i] = 16'(100 + i);
    send_pay();
    stream_chk(FL);
    finish_frame();
    send(16'hFFFF); tick(); tick(); send(16'hFFFF); tick(); send(16'hFFFF);
    check("t2_gap_hdr", 32'(busy), 32'd1);
    for (int i = 0; i < FL; i++) pay[i] = 16'(150 + i);
    send_pay();
    stream_chk(FL);
    finish_frame();

    // 3: header-valued payload, fft_ready held low for a while
    pay[0] = 16'h0001; pay[1] = 16'hFFFF; pay[2] = 16'hFFFF; pay[3] = 16'hFFFF; pay[4] = 16'h0005;
    pay[5] = 16'h0006; pay[6] = 16'hFFFF; pay[7] = 16'hFFFF; pay[8] = 16'hFFFF; pay[9] = 16'h000A;
    fft_ready = 1'b0;
    send_hdr();
    send_pay();
    repeat (3) tick();
    check("t3_no_start", 32'(fft_start), 32'd0);
    check("t3_wait_busy", 32'(busy), 32'd1);
    fft_ready = 1'b1;
    stream_chk(FL);
    check("t3_drop", 32'(drop_cnt), 32'd0);
    finish_frame();

    // 4: headers during WAIT_DONE count as drops and saturate
    for (int i = 0; i < FL; i++) pay[i] = 16'(200 + i);
    send_hdr();
    send_pay();
    stream_chk(FL);
    send_hdr();
    check("t4_drop1", 32'(drop_cnt), 32'd1);
    for (int h = 2; h <= 300; h++) begin
      send_hdr();
      if (h == 254) check("t4_drop254", 32'(drop_cnt), 32'd254);
      if (h == 255) check("t4_drop255", 32'(drop_cnt), 32'd255);
    end
    check("t4_drop_sat", 32'(drop_cnt), 32'd255);
    check("t4_busy", 32'(busy), 32'd1);
    finish_frame();

    // 5: asynchronous reset mid-stream
    for (int i = 0; i < FL; i++) pay[i] = 16'(300 + i);
    send_hdr();
    send_pay();
    stream_chk(4);
    rst_n = 1'b0;
    #2;
    check("t5_vld",  32'(out_vld), 32'd0);
    check("t5_data", 32'(out_data), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < FL; i++) pay[i] = 16'(400 + i);
    send_hdr();
    send_pay();
    stream_chk(FL);
    finish_frame();

`ifdef FFT_TIMEOUT_EN
    // 6: FFT never signals done
    for (int i = 0; i < FL; i++) pay[i] = 16'(500 + i);
    send_hdr();
    send_pay();
    stream_chk(FL);
    repeat (14) tick();
    check("t6_no_timeout", 32'(timeout), 32'd0);
    tick();
    check("t6_timeout", 32'(timeout), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_no_fdone", 32'(frame_done), 32'd0);
    for (int i = 0; i < FL; i++) pay[i] = 16'(600 + i);
    send_hdr();
    send_pay();
    stream_chk(FL);
    finish_frame();
    check("t6_sticky", 32'(timeout), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
